// File: rtl/ac97_pcm_fifo_if.sv
// Producer-side sample handshake for the AC'97 PCM playback FIFO.
// Carries one stereo pair {left, right} per accepted valid/ready transfer.
interface ac97_pcm_fifo_if;
  logic [19:0] in_left;
  logic [19:0] in_right;
  logic        in_valid;
  logic        in_ready;

  modport master (
    output in_left,
    output in_right,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_left,
    input  in_right,
    input  in_valid,
    output in_ready
  );
endinterface

// File: rtl/ac97_pcm_fifo.sv
// Stereo sample FIFO feeding AC-link slots 3/4: one pair popped per frame strobe,
// with deterministic underrun behaviour and a saturating underrun counter.
module ac97_pcm_fifo #(
  parameter int DEPTH_LOG2    = 4,
  parameter bit UNDERRUN_ZERO = 1'b1
) (
  input  logic                  ac97_bitclk,
  input  logic                  ac97_rst,
  input  logic                  ac97_strobe,
  input  logic                  enable,
  ac97_pcm_fifo_if.slave        in_if,
  output logic [19:0]           ac97_out_slot3,
  output logic                  ac97_out_slot3_valid,
  output logic [19:0]           ac97_out_slot4,
  output logic                  ac97_out_slot4_valid,
  output logic [DEPTH_LOG2:0]   fifo_level,
  output logic [15:0]           underrun_count,
  input  logic                  underrun_clear
);
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2+1)'(DEPTH);

  logic [39:0]           mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic [19:0]           left_q, left_d;
  logic [19:0]           right_q, right_d;
  logic                  valid_q, valid_d;
  logic [15:0]           count_q, count_d;
  logic                  push, pop, underrun, frame;

  // No full-bypass: a same-cycle pop never lets a push in while full.
  assign in_if.in_ready = (level_q != FULL_LEVEL) && !ac97_rst;

  assign push     = in_if.in_valid && in_if.in_ready;
  assign frame    = ac97_strobe && enable;
  assign pop      = frame && (level_q != '0);
  assign underrun = frame && (level_q == '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    left_d   = left_q;
    right_d  = right_q;
    valid_d  = valid_q;
    count_d  = count_q;

    if (push) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);

    case ({push, pop})
      2'b10:   level_d = level_q + (DEPTH_LOG2+1)'(1);
      2'b01:   level_d = level_q - (DEPTH_LOG2+1)'(1);
      default: level_d = level_q;
    endcase

    if (ac97_strobe) begin
      if (!enable) begin
        left_d  = '0;
        right_d = '0;
        valid_d = 1'b0;
      end else if (pop) begin
        {left_d, right_d} = mem_q[rd_ptr_q];
        valid_d = 1'b1;
      end else begin
        // Underrun: the pair being pushed this cycle is stored, not bypassed.
        valid_d = 1'b1;
        if (UNDERRUN_ZERO) begin
          left_d  = '0;
          right_d = '0;
        end
      end
    end

    if (underrun_clear) begin
      count_d = '0;
    end else if (underrun && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge ac97_bitclk) begin
    if (push) mem_q[wr_ptr_q] <= {in_if.in_left, in_if.in_right};
  end

  always_ff @(posedge ac97_bitclk or posedge ac97_rst) begin
    if (ac97_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      left_q   <= '0;
      right_q  <= '0;
      valid_q  <= 1'b0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      left_q   <= left_d;
      right_q  <= right_d;
      valid_q  <= valid_d;
      count_q  <= count_d;
    end
  end

  assign ac97_out_slot3       = left_q;
  assign ac97_out_slot4       = right_q;
  assign ac97_out_slot3_valid = valid_q;
  assign ac97_out_slot4_valid = valid_q;
  assign fifo_level           = level_q;
  assign underrun_count       = count_q;
endmodule

// File: tb/tb_ac97_pcm_fifo.sv
// Directed bench for ac97_pcm_fifo: vector table plus hand sequences for
// fill/wrap, repeat-on-underrun and asynchronous reset mid-frame.
module tb_ac97_pcm_fifo;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic stb_a = 1'b0, en_a = 1'b1, clr_a = 1'b0;
  logic stb_b = 1'b0, en_b = 1'b1, clr_b = 1'b0;

  logic [19:0] s3_a, s4_a, s3_b, s4_b;
  logic        v3_a, v4_a, v3_b, v4_b;
  logic [4:0]  lvl_a, lvl_b;
  logic [15:0] cnt_a, cnt_b;

  int tests = 0;
  int failures = 0;

  ac97_pcm_fifo_if if_a ();
  ac97_pcm_fifo_if if_b ();

  always #5 clk = ~clk;

  ac97_pcm_fifo #(.DEPTH_LOG2(4), .UNDERRUN_ZERO(1'b1)) dut_a (
    .ac97_bitclk(clk), .ac97_rst(rst), .ac97_strobe(stb_a), .enable(en_a),
    .in_if(if_a),
    .ac97_out_slot3(s3_a), .ac97_out_slot3_valid(v3_a),
    .ac97_out_slot4(s4_a), .ac97_out_slot4_valid(v4_a),
    .fifo_level(lvl_a), .underrun_count(cnt_a), .underrun_clear(clr_a)
  );

  ac97_pcm_fifo #(.DEPTH_LOG2(4), .UNDERRUN_ZERO(1'b0)) dut_b (
    .ac97_bitclk(clk), .ac97_rst(rst), .ac97_strobe(stb_b), .enable(en_b),
    .in_if(if_b),
    .ac97_out_slot3(s3_b), .ac97_out_slot3_valid(v3_b),
    .ac97_out_slot4(s4_b), .ac97_out_slot4_valid(v4_b),
    .fifo_level(lvl_b), .underrun_count(cnt_b), .underrun_clear(clr_b)
  );

  typedef struct {
    logic        stb, en, vld, clr;
    logic [19:0] l, r;
    logic [19:0] e3, e4;
    logic        ev;
    logic [4:0]  elvl;
    logic [15:0] ecnt;
  } vec_t;

  vec_t vecs [24];

  function automatic vec_t mk(input logic stb, input logic en, input logic vld,
                              input logic clr, input logic [19:0] l,
                              input logic [19:0] r, input logic [19:0] e3,
                              input logic [19:0] e4, input logic ev,
                              input logic [4:0] elvl, input logic [15:0] ecnt);
    vec_t v;
    v.stb = stb; v.en = en; v.vld = vld; v.clr = clr;
    v.l = l; v.r = r; v.e3 = e3; v.e4 = e4; v.ev = ev;
    v.elvl = elvl; v.ecnt = ecnt;
    return v;
  endfunction

  function automatic logic [19:0] pat_l(input int i);
    logic [15:0] k;
    k = i[15:0];
    return {4'hA, k};
  endfunction

  function automatic logic [19:0] pat_r(input int i);
    logic [15:0] k;
    k = i[15:0];
    return {4'h5, ~k};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_a(input string tag, input logic [19:0] e3, input logic [19:0] e4,
                         input logic ev, input logic [4:0] elvl, input logic [15:0] ecnt);
    check({tag, " slot3"}, 32'(s3_a), 32'(e3));
    check({tag, " slot4"}, 32'(s4_a), 32'(e4));
    check({tag, " valid3"}, 32'(v3_a), 32'(ev));
    check({tag, " valid4"}, 32'(v4_a), 32'(ev));
    check({tag, " level"}, 32'(lvl_a), 32'(elvl));
    check({tag, " count"}, 32'(cnt_a), 32'(ecnt));
  endtask

  task automatic reset_pulse();
    #2 rst = 1'b1;
    tick();
    tick();
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  initial begin
    int push_idx, popped, mlevel, cyc;
    logic did_push, did_pop, first_strobe;

    if_a.in_valid = 1'b0; if_a.in_left = '0; if_a.in_right = '0;
    if_b.in_valid = 1'b0; if_b.in_left = '0; if_b.in_right = '0;

    vecs[0]  = mk(1,1,0,0, 20'h0, 20'h0, 20'h0, 20'h0, 1, 5'd0, 16'd1);
    vecs[1]  = mk(0,1,0,0, 20'h0, 20'h0, 20'h0, 20'h0, 1, 5'd0, 16'd1);
    vecs[2]  = mk(1,1,0,0, 20'h0, 20'h0, 20'h0, 20'h0, 1, 5'd0, 16'd2);
    vecs[3]  = mk(1,1,0,0, 20'h0, 20'h0, 20'h0, 20'h0, 1, 5'd0, 16'd3);
    vecs[4]  = mk(0,1,0,1, 20'h0, 20'h0, 20'h0, 20'h0, 1, 5'd0, 16'd0);
    vecs[5]  = mk(0,1,1,0, 20'h00001, 20'hFFFFF, 20'h0, 20'h0, 1, 5'd1, 16'd0);
    vecs[6]  = mk(0,1,1,0, 20'h00002, 20'hFFFFE, 20'h0, 20'h0, 1, 5'd2, 16'd0);
    vecs[7]  = mk(0,1,1,0, 20'h00003, 20'hFFFFD, 20'h0, 20'h0, 1, 5'd3, 16'd0);
    vecs[8]  = mk(1,1,0,0, 20'h0, 20'h0, 20'h00001, 20'hFFFFF, 1, 5'd2, 16'd0);
    vecs[9]  = mk(0,1,0,0, 20'h0, 20'h0, 20'h00001, 20'hFFFFF, 1, 5'd2, 16'd0);
    vecs[10] = mk(1,1,0,0, 20'h0, 20'h0, 20'h00002, 20'hFFFFE, 1, 5'd1, 16'd0);
    vecs[11] = mk(1,1,0,0, 20'h0, 20'h0, 20'h00003, 20'hFFFFD, 1, 5'd0, 16'd0);
    vecs[12] = mk(1,1,1,0, 20'h00004, 20'h00004, 20'h0, 20'h0, 1, 5'd1, 16'd1);
    vecs[13] = mk(1,1,0,1, 20'h0, 20'h0, 20'h00004, 20'h00004, 1, 5'd0, 16'd0);
    vecs[14] = mk(1,1,0,1, 20'h0, 20'h0, 20'h0, 20'h0, 1, 5'd0, 16'd0);
    vecs[15] = mk(1,0,0,0, 20'h0, 20'h0, 20'h0, 20'h0, 0, 5'd0, 16'd0);
    vecs[16] = mk(0,1,1,0, 20'h11111, 20'hAAAAA, 20'h0, 20'h0, 0, 5'd1, 16'd0);
    vecs[17] = mk(0,1,1,0, 20'h22222, 20'hBBBBB, 20'h0, 20'h0, 0, 5'd2, 16'd0);
    vecs[18] = mk(0,1,1,0, 20'h33333, 20'hCCCCC, 20'h0, 20'h0, 0, 5'd3, 16'd0);
    vecs[19] = mk(0,1,1,0, 20'h44444, 20'hDDDDD, 20'h0, 20'h0, 0, 5'd4, 16'd0);
    vecs[20] = mk(1,0,0,0, 20'h0, 20'h0, 20'h0, 20'h0, 0, 5'd4, 16'd0);
    vecs[21] = mk(1,1,0,0, 20'h0, 20'h0, 20'h11111, 20'hAAAAA, 1, 5'd3, 16'd0);
    vecs[22] = mk(1,1,1,0, 20'h55555, 20'hEEEEE, 20'h22222, 20'hBBBBB, 1, 5'd3, 16'd0);
    vecs[23] = mk(1,0,0,0, 20'h0, 20'h0, 20'h0, 20'h0, 0, 5'd3, 16'd0);

    // Reset state while asserted, then release.
    #1 rst = 1'b1;
    tick();
    tick();
    check_a("reset", 20'h0, 20'h0, 1'b0, 5'd0, 16'd0);
    check("reset in_ready", 32'(if_a.in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("release in_ready", 32'(if_a.in_ready), 32'd1);

    // Table-driven vectors on the UNDERRUN_ZERO=1 instance.
    for (int i = 0; i < 24; i++) begin
      stb_a = vecs[i].stb; en_a = vecs[i].en; clr_a = vecs[i].clr;
      if_a.in_valid = vecs[i].vld; if_a.in_left = vecs[i].l; if_a.in_right = vecs[i].r;
      tick();
      check_a($sformatf("vec%0d", i), vecs[i].e3, vecs[i].e4, vecs[i].ev,
              vecs[i].elvl, vecs[i].ecnt);
      check($sformatf("vec%0d in_ready", i), 32'(if_a.in_ready),
            32'(vecs[i].elvl != 5'd16));
    end
    stb_a = 1'b0; en_a = 1'b1; clr_a = 1'b0; if_a.in_valid = 1'b0;

    // UNDERRUN_ZERO=0: second frame repeats the last popped pair.
    if_b.in_valid = 1'b1; if_b.in_left = 20'h12345; if_b.in_right = 20'h54321;
    tick();
    if_b.in_valid = 1'b0; stb_b = 1'b1;
    tick();
    check("uz0 frame1 slot3", 32'(s3_b), 32'h12345);
    check("uz0 frame1 slot4", 32'(s4_b), 32'h54321);
    check("uz0 frame1 count", 32'(cnt_b), 32'd0);
    tick();
    stb_b = 1'b0;
    check("uz0 frame2 slot3", 32'(s3_b), 32'h12345);
    check("uz0 frame2 slot4", 32'(s4_b), 32'h54321);
    check("uz0 frame2 valid3", 32'(v3_b), 32'd1);
    check("uz0 frame2 valid4", 32'(v4_b), 32'd1);
    check("uz0 frame2 count", 32'(cnt_b), 32'd1);
    check("uz0 frame2 level", 32'(lvl_b), 32'd0);

    // Fill to full, hold off a 17th pair, then drain across the pointer wrap.
    reset_pulse();
    for (int i = 0; i < 16; i++) begin
      if_a.in_valid = 1'b1; if_a.in_left = pat_l(i); if_a.in_right = pat_r(i);
      tick();
    end
    check("full level", 32'(lvl_a), 32'd16);
    check("full in_ready", 32'(if_a.in_ready), 32'd0);
    if_a.in_left = pat_l(16); if_a.in_right = pat_r(16);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("held17 level%0d", i), 32'(lvl_a), 32'd16);
    end

    push_idx = 16; popped = 0; mlevel = 16; first_strobe = 1'b1;
    for (cyc = 0; cyc < 1000 && popped < 36; cyc++) begin
      stb_a = (cyc % 8 == 0);
      if_a.in_valid = (push_idx < 36);
      if_a.in_left = pat_l(push_idx); if_a.in_right = pat_r(push_idx);
      did_push = if_a.in_valid && if_a.in_ready;
      did_pop = stb_a && (mlevel > 0);
      tick();
      if (did_push) begin push_idx++; mlevel++; end
      if (did_pop) begin
        mlevel--;
        check($sformatf("wrap pop%0d slot3", popped), 32'(s3_a), 32'(pat_l(popped)));
        check($sformatf("wrap pop%0d slot4", popped), 32'(s4_a), 32'(pat_r(popped)));
        popped++;
      end
      if (stb_a && first_strobe) begin
        first_strobe = 1'b0;
        check("after pop in_ready", 32'(if_a.in_ready), 32'd1);
        check("after pop level", 32'(lvl_a), 32'd15);
      end
    end
    stb_a = 1'b0; if_a.in_valid = 1'b0;
    check("wrap all popped", 32'(popped), 32'd36);
    check("wrap count", 32'(cnt_a), 32'd0);

    // Asynchronous reset 100 cycles after a strobe with 5 pairs queued.
    stb_a = 1'b1;
    tick();
    stb_a = 1'b0;
    check("pre-rst underrun count", 32'(cnt_a), 32'd1);
    for (int i = 0; i < 6; i++) begin
      if_a.in_valid = 1'b1; if_a.in_left = pat_l(100 + i); if_a.in_right = pat_r(100 + i);
      tick();
    end
    if_a.in_valid = 1'b0; stb_a = 1'b1;
    tick();
    stb_a = 1'b0;
    check("pre-rst slot3", 32'(s3_a), 32'(pat_l(100)));
    check("pre-rst level", 32'(lvl_a), 32'd5);
    repeat (100) tick();
    #2 rst = 1'b1;
    #1;
    check_a("midframe rst", 20'h0, 20'h0, 1'b0, 5'd0, 16'd0);
    check("midframe rst in_ready", 32'(if_a.in_ready), 32'd0);
    tick();
    @(negedge clk);
    rst = 1'b0;
    stb_a = 1'b1;
    tick();
    stb_a = 1'b0;
    check_a("post-rst strobe", 20'h0, 20'h0, 1'b1, 5'd0, 16'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end
endmodule
